// File: rtl/mem_bus_pkg.sv
// Shared definitions for the core data-side memory request path.
// Contents:
//   tgt_e           - downstream target index (TGT_RAM = 0, TGT_MMIO = 1)
//   R1_BASE_DEFAULT - default base address of the MMIO (port 1) region
//   R1_MASK_DEFAULT - default mask applied before comparing against the base
package mem_bus_pkg;

    typedef enum logic {
        TGT_RAM  = 1'b0,
        TGT_MMIO = 1'b1
    } tgt_e;

    localparam logic [31:0] R1_BASE_DEFAULT = 32'h1000_0000;
    localparam logic [31:0] R1_MASK_DEFAULT = 32'hF000_0000;

endpackage

// File: rtl/mem_req_slot.sv
// One-entry valid/ready register slice for a load/store request.
// Holds address, write flag, write data and byte strobes. A new request can be
// loaded in the same cycle the held one is taken downstream, so the slice
// sustains one request per cycle. Contents only change on a load, so they are
// stable while out_valid is high and out_ready is low.
// Ports:
//   clk, rst_n                          - clock, synchronous active-low reset
//   in_valid / in_ready                 - upstream handshake
//   in_addr, in_we, in_wdata, in_wstrb  - request to load
//   out_valid / out_ready               - downstream handshake
//   out_addr, out_we, out_wdata, out_wstrb - held request
module mem_req_slot #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [AW-1:0]  in_addr,
    input  logic           in_we,
    input  logic [N-1:0]   in_wdata,
    input  logic [N/8-1:0] in_wstrb,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  out_addr,
    output logic           out_we,
    output logic [N-1:0]   out_wdata,
    output logic [N/8-1:0] out_wstrb
);

    logic           valid_q;
    logic [AW-1:0]  addr_q;
    logic           we_q;
    logic [N-1:0]   wdata_q;
    logic [N/8-1:0] wstrb_q;

    // Empty, or the held entry leaves this cycle.
    assign in_ready = ~valid_q | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            addr_q  <= in_addr;
            we_q    <= in_we;
            wdata_q <= in_wdata;
            wstrb_q <= in_wstrb;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_we    = we_q;
    assign out_wdata = wdata_q;
    assign out_wstrb = wstrb_q;

endmodule

// File: rtl/mem_req_demux_1x2.sv
// 1-to-2 request router: steers one load/store stream to data RAM (port 0) or
// MMIO (port 1) by address match, through a one-entry registered slot, and
// returns responses in order on one upstream channel (1-cycle latency).
// Ordering is kept without a reorder buffer: a request to the other target is
// held off until every outstanding request has been answered.
// Ports:
//   clk, rst_n                         - clock, synchronous active-low reset
//   req_valid/req_ready, req_addr, req_we, req_wdata, req_wstrb - upstream request
//   m0_valid/m0_ready, m1_valid/m1_ready - per-target request handshake
//   m_addr, m_we, m_wdata, m_wstrb      - slot contents, shared by both targets
//   m0_rsp_valid/m0_rsp_rdata, m1_rsp_valid/m1_rsp_rdata - target responses
//   rsp_valid, rsp_rdata                - upstream response, no backpressure
//   err (only with MEM_REQ_DEMUX_ERR_EN) - sticky protocol error flag
// Build option: define MEM_REQ_DEMUX_ERR_EN to add the err output.
module mem_req_demux_1x2
    import mem_bus_pkg::*;
#(
    parameter int unsigned   N       = 32,
    parameter int unsigned   AW      = 32,
    parameter logic [AW-1:0] R1_BASE = AW'(R1_BASE_DEFAULT),
    parameter logic [AW-1:0] R1_MASK = AW'(R1_MASK_DEFAULT),
    parameter int unsigned   MAX_OUT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [AW-1:0]  req_addr,
    input  logic           req_we,
    input  logic [N-1:0]   req_wdata,
    input  logic [N/8-1:0] req_wstrb,
    output logic           m0_valid,
    output logic           m1_valid,
    input  logic           m0_ready,
    input  logic           m1_ready,
    output logic [AW-1:0]  m_addr,
    output logic           m_we,
    output logic [N-1:0]   m_wdata,
    output logic [N/8-1:0] m_wstrb,
    input  logic           m0_rsp_valid,
    input  logic           m1_rsp_valid,
    input  logic [N-1:0]   m0_rsp_rdata,
    input  logic [N-1:0]   m1_rsp_rdata,
    output logic           rsp_valid,
    output logic [N-1:0]   rsp_rdata
`ifdef MEM_REQ_DEMUX_ERR_EN
    ,
    output logic           err
`endif
);

    localparam int unsigned   PW       = $clog2(MAX_OUT + 1);
    localparam logic [PW-1:0] MAX_PEND = PW'(MAX_OUT);

    tgt_e          cur_tgt_q, cur_tgt_d, sel_tgt;
    logic [PW-1:0] pend_q, pend_d;
    logic          slot_valid, slot_in_ready, slot_out_ready;
    logic          accept, rsp_hit, pend_dec;
    logic [N-1:0]  hit_rdata;
    logic          rsp_valid_q;
    logic [N-1:0]  rsp_rdata_q;

    assign sel_tgt = ((req_addr & R1_MASK) == R1_BASE) ? TGT_MMIO : TGT_RAM;

    // The slot only ever holds a request for cur_tgt: cur_tgt can change only
    // when pend == 0, which implies the slot is empty or being refilled.
    assign slot_out_ready = (cur_tgt_q == TGT_MMIO) ? m1_ready : m0_ready;
    assign m0_valid       = slot_valid & (cur_tgt_q == TGT_RAM);
    assign m1_valid       = slot_valid & (cur_tgt_q == TGT_MMIO);

    // Depends on m*_ready through the slot, never on m*_rsp_valid.
    assign req_ready = (pend_q < MAX_PEND) & slot_in_ready
                     & ((pend_q == '0) | (sel_tgt == cur_tgt_q));
    assign accept    = req_valid & req_ready;

    always_comb begin
        rsp_hit   = m0_rsp_valid;
        hit_rdata = m0_rsp_rdata;
        if (cur_tgt_q == TGT_MMIO) begin
            rsp_hit   = m1_rsp_valid;
            hit_rdata = m1_rsp_rdata;
        end
        // A response with nothing pending must not underflow the counter.
        pend_dec  = rsp_hit & (pend_q != '0);
        pend_d    = pend_q;
        cur_tgt_d = cur_tgt_q;
        if (accept) begin
            cur_tgt_d = sel_tgt;
        end
        if (accept && !pend_dec) begin
            pend_d = pend_q + 1'b1;
        end else if (!accept && pend_dec) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q      <= '0;
            cur_tgt_q   <= TGT_RAM;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            pend_q      <= pend_d;
            cur_tgt_q   <= cur_tgt_d;
            rsp_valid_q <= rsp_hit;
            if (rsp_hit) begin
                rsp_rdata_q <= hit_rdata;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    mem_req_slot #(
        .N  (N),
        .AW (AW)
    ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_ready  (slot_in_ready),
        .in_addr   (req_addr),
        .in_we     (req_we),
        .in_wdata  (req_wdata),
        .in_wstrb  (req_wstrb),
        .out_valid (slot_valid),
        .out_ready (slot_out_ready),
        .out_addr  (m_addr),
        .out_we    (m_we),
        .out_wdata (m_wdata),
        .out_wstrb (m_wstrb)
    );

`ifdef MEM_REQ_DEMUX_ERR_EN
    logic rsp_other;
    logic err_q;

    assign rsp_other = (cur_tgt_q == TGT_MMIO) ? m0_rsp_valid : m1_rsp_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (rsp_other || (rsp_hit && (pend_q == '0))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_mem_req_demux_1x2.sv
// Randomised self-checking bench for mem_req_demux_1x2. A transaction-level
// model (queue for the slot, outstanding count, per-target response queues)
// predicts every output each cycle.
module tb_mem_req_demux_1x2;

    localparam int unsigned N       = 32;
    localparam int unsigned AW      = 32;
    localparam int unsigned MAX_OUT = 4;
    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam logic [31:0] MASK    = 32'hF000_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0, req_ready;
    logic [AW-1:0]  req_addr = '0;
    logic           req_we = 1'b0;
    logic [N-1:0]   req_wdata = '0;
    logic [N/8-1:0] req_wstrb = '0;
    logic           m0_valid, m1_valid;
    logic           m0_ready = 1'b0, m1_ready = 1'b0;
    logic [AW-1:0]  m_addr;
    logic           m_we;
    logic [N-1:0]   m_wdata;
    logic [N/8-1:0] m_wstrb;
    logic           m0_rsp_valid = 1'b0, m1_rsp_valid = 1'b0;
    logic [N-1:0]   m0_rsp_rdata = '0, m1_rsp_rdata = '0;
    logic           rsp_valid;
    logic [N-1:0]   rsp_rdata;
`ifdef MEM_REQ_DEMUX_ERR_EN
    logic           err;
`endif

    always #5 clk = ~clk;

    mem_req_demux_1x2 #(
        .N       (N),
        .AW      (AW),
        .R1_BASE (BASE),
        .R1_MASK (MASK),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .m0_valid     (m0_valid),
        .m1_valid     (m1_valid),
        .m0_ready     (m0_ready),
        .m1_ready     (m1_ready),
        .m_addr       (m_addr),
        .m_we         (m_we),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m0_rsp_valid (m0_rsp_valid),
        .m1_rsp_valid (m1_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_rsp_rdata (m1_rsp_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata)
`ifdef MEM_REQ_DEMUX_ERR_EN
        ,
        .err          (err)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          tgt;
    } req_t;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    req_t        slot_q[$];
    int          due0[$];
    int          due1[$];
    int          outstanding = 0;
    int          cur_tgt = 0;
    logic        exp_rsp_valid = 1'b0;
    logic [31:0] exp_rsp_data = '0;
    logic        exp_err = 1'b0;
    int          cyc = 0;

    // Stimulus knobs.
    int req_pct = 60;
    int rdy_pct = 70;
    int max_dly = 3;
    bit stall = 1'b0;
    bit ram_only = 1'b0;
    bit spur1 = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m1_rsp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        cyc += 2;
        #1;
        slot_q.delete();
        due0.delete();
        due1.delete();
        outstanding = 0;
        cur_tgt = 0;
        exp_rsp_valid = 1'b0;
        exp_rsp_data = '0;
        exp_err = 1'b0;
        check_eq("rst_m0_valid", m0_valid, 1'b0);
        check_eq("rst_m1_valid", m1_valid, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_req_ready", req_ready, 1'b1);
`ifdef MEM_REQ_DEMUX_ERR_EN
        check_eq("rst_err", err, 1'b0);
`endif
        rst_n = 1'b1;
    endtask

    task automatic do_cycle();
        logic [31:0] a;
        logic        sel, fire, hit, other, exp_ready;
        int          st;
        req_t        r;
        @(negedge clk);
        // Targets answer in order, no earlier than their due cycle.
        m0_rsp_valid = !stall && due0.size() > 0 && due0[0] <= cyc;
        m1_rsp_valid = spur1 || (!stall && due1.size() > 0 && due1[0] <= cyc);
        m0_rsp_rdata = $urandom;
        m1_rsp_rdata = $urandom;
        m0_ready  = $urandom_range(0, 99) < rdy_pct;
        m1_ready  = $urandom_range(0, 99) < rdy_pct;
        req_valid = $urandom_range(0, 99) < req_pct;
        a = $urandom;
        if (!ram_only && $urandom_range(0, 1) == 1) a[31:28] = 4'h1;
        else if (a[31:28] == 4'h1) a[31:28] = 4'h9;
        req_addr  = a;
        req_we    = 1'($urandom_range(0, 1));
        req_wdata = $urandom;
        req_wstrb = 4'($urandom_range(0, 15));
        #1;
        st = (slot_q.size() > 0) ? slot_q[0].tgt : -1;
        check_eq("m0_valid", m0_valid, st == 0);
        check_eq("m1_valid", m1_valid, st == 1);
        if (st >= 0) begin
            check_eq("m_addr", m_addr, slot_q[0].addr);
            check_eq("m_we", m_we, slot_q[0].we);
            check_eq("m_wdata", m_wdata, slot_q[0].wdata);
            check_eq("m_wstrb", m_wstrb, slot_q[0].wstrb);
        end
        fire = (st == 0 && m0_ready) || (st == 1 && m1_ready);
        sel  = (req_addr & MASK) == BASE;
        exp_ready = (outstanding < int'(MAX_OUT)) && (st < 0 || fire)
                    && (outstanding == 0 || int'(sel) == cur_tgt);
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("rsp_valid", rsp_valid, exp_rsp_valid);
        check_eq("rsp_rdata", rsp_rdata, exp_rsp_data);
`ifdef MEM_REQ_DEMUX_ERR_EN
        check_eq("err", err, exp_err);
`endif
        // Advance the model across the coming edge.
        hit   = (cur_tgt == 1) ? m1_rsp_valid : m0_rsp_valid;
        other = (cur_tgt == 1) ? m0_rsp_valid : m1_rsp_valid;
        if (other || (hit && outstanding == 0)) exp_err = 1'b1;
        exp_rsp_valid = hit;
        if (hit) exp_rsp_data = (cur_tgt == 1) ? m1_rsp_rdata : m0_rsp_rdata;
        if (hit && outstanding > 0) begin
            outstanding--;
            if (cur_tgt == 1 && due1.size() > 0) void'(due1.pop_front());
            if (cur_tgt == 0 && due0.size() > 0) void'(due0.pop_front());
        end
        if (fire) begin
            r = slot_q.pop_front();
            if (r.tgt == 1) due1.push_back(cyc + 1 + $urandom_range(0, max_dly));
            else due0.push_back(cyc + 1 + $urandom_range(0, max_dly));
        end
        if (req_valid && exp_ready) begin
            r.addr  = req_addr;
            r.we    = req_we;
            r.wdata = req_wdata;
            r.wstrb = req_wstrb;
            r.tgt   = int'(sel);
            slot_q.push_back(r);
            outstanding++;
            cur_tgt = int'(sel);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    initial begin
        do_reset();
`ifdef MEM_REQ_DEMUX_ERR_EN
        // Stray MMIO response while idle on RAM must raise err.
        req_pct = 0;
        spur1 = 1'b1;
        run(1);
        spur1 = 1'b0;
        run(2);
        do_reset();
`endif
        // General mixed traffic.
        req_pct = 60; rdy_pct = 70; max_dly = 3;
        run(300);
        // Fill to MAX_OUT with responses withheld, then release.
        ram_only = 1'b1; stall = 1'b1; req_pct = 100; rdy_pct = 100;
        run(12);
        stall = 1'b0;
        run(40);
        // Heavy traffic with downstream backpressure.
        ram_only = 1'b0; req_pct = 90; rdy_pct = 50;
        run(300);
        // Reset with requests outstanding.
        stall = 1'b1; req_pct = 100; rdy_pct = 100;
        run(6);
        stall = 1'b0;
        do_reset();
        req_pct = 70; rdy_pct = 80; max_dly = 5;
        run(200);
        // Drain.
        req_pct = 0; rdy_pct = 100;
        run(30);
        check_eq("drained", outstanding, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
